// File: rtl/minirisc_datapath_p.sv
// MiniRISC datapath: register file, flag-producing ALU and a handshaked data-memory port.
// A two-state FSM holds the controller off through busy while a load/store waits for ack.

module minirisc_alu #(
  parameter int W = 8
) (
  input  logic [2:0]   op,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         c_in,
  input  logic         v_in,
  output logic [W-1:0] r,
  output logic         z,
  output logic         c,
  output logic         n,
  output logic         v
);
  logic [W:0] ext;

  always_comb begin
    ext = '0;
    r   = '0;
    c   = c_in;
    v   = v_in;
    case (op)
      3'd0: begin
        ext = {1'b0, x} + {1'b0, y};
        r   = ext[W-1:0];
        c   = ext[W];
        v   = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
      end
      3'd1: begin
        // The extra bit of the wide subtract is the borrow
        ext = {1'b0, x} - {1'b0, y};
        r   = ext[W-1:0];
        c   = ext[W];
        v   = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
      end
      3'd2: r = x & y;
      3'd3: r = x | y;
      3'd4: r = x ^ y;
      3'd6: begin
        r = {x[W-2:0], 1'b0};
        c = x[W-1];
      end
      3'd7: begin
        r = {1'b0, x[W-1:1]};
        c = x[0];
      end
      default: r = y;
    endcase
    z = (r == '0);
    n = r[W-1];
  end
endmodule

module minirisc_datapath_p #(
  parameter  int DATA_W  = 8,
  parameter  int REG_NUM = 16,
  localparam int RA_W    = $clog2(REG_NUM)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              op_valid,
  input  logic [1:0]        op_kind,
  input  logic [2:0]        alu_op,
  input  logic              op2_sel,
  input  logic [DATA_W-1:0] const_data,
  input  logic [RA_W-1:0]   reg_addr_x,
  input  logic [RA_W-1:0]   reg_addr_y,
  input  logic [3:0]        flag_din,
  input  logic              flag_wr,
  output logic              busy,
  output logic [DATA_W-1:0] data_mem_addr,
  output logic [DATA_W-1:0] data_mem_dout,
  input  logic [DATA_W-1:0] data_mem_din,
  output logic              data_mem_rd,
  output logic              data_mem_wr,
  input  logic              data_mem_ack,
  output logic              flag_z,
  output logic              flag_c,
  output logic              flag_n,
  output logic              flag_v,
  output logic [DATA_W-1:0] jump_address,
  input  logic              dbg_is_brk,
  input  logic [RA_W-1:0]   dbg_addr_in,
  input  logic [DATA_W-1:0] dbg_data_in,
  input  logic              dbg_reg_wr,
  output logic [DATA_W-1:0] dbg_reg_dout
);
  localparam logic [1:0] K_ALU   = 2'd0;
  localparam logic [1:0] K_LOAD  = 2'd1;
  localparam logic [1:0] K_STORE = 2'd2;

  typedef enum logic {IDLE, MEM_WAIT} state_t;

  state_t                         state;
  logic [REG_NUM-1:0][DATA_W-1:0] rf;
  logic [RA_W-1:0]                addr_x, ld_dest, wa;
  logic [DATA_W-1:0]              rd_x, rd_y, op2, lat_addr, lat_data, alu_r, wd;
  logic                           alu_z, alu_c, alu_n, alu_v;
  logic                           is_load, idle, brk, issue, we;

  assign idle  = (state == IDLE);
  assign brk   = idle & dbg_is_brk;
  assign issue = idle & op_valid & ~dbg_is_brk;

  // While halted, port X is handed to the debugger
  assign addr_x = brk ? dbg_addr_in : reg_addr_x;
  assign rd_x   = rf[addr_x];
  assign rd_y   = rf[reg_addr_y];
  assign op2    = op2_sel ? rd_y : const_data;

  assign jump_address  = op2;
  assign dbg_reg_dout  = rd_x;
  assign data_mem_addr = idle ? op2 : lat_addr;
  assign data_mem_dout = idle ? rd_x : lat_data;

  minirisc_alu #(.W(DATA_W)) u_alu (
    .op   (alu_op),
    .x    (rd_x),
    .y    (op2),
    .c_in (flag_c),
    .v_in (flag_v),
    .r    (alu_r),
    .z    (alu_z),
    .c    (alu_c),
    .n    (alu_n),
    .v    (alu_v)
  );

  // Single write port: debug, ALU result and load write-back are mutually exclusive
  always_comb begin
    we = 1'b0;
    wa = '0;
    wd = '0;
    if (brk && dbg_reg_wr) begin
      we = 1'b1;
      wa = dbg_addr_in;
      wd = dbg_data_in;
    end else if (issue && op_kind == K_ALU) begin
      we = 1'b1;
      wa = reg_addr_x;
      wd = alu_r;
    end else if (!idle && data_mem_ack && is_load) begin
      we = 1'b1;
      wa = ld_dest;
      wd = data_mem_din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rf <= '0;
    else if (we) rf[wa] <= wd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      data_mem_rd <= 1'b0;
      data_mem_wr <= 1'b0;
      lat_addr    <= '0;
      lat_data    <= '0;
      ld_dest     <= '0;
      is_load     <= 1'b0;
      {flag_z, flag_c, flag_n, flag_v} <= 4'b0000;
    end else begin
      case (state)
        IDLE: if (!dbg_is_brk) begin
          if (flag_wr)
            {flag_z, flag_c, flag_n, flag_v} <= flag_din;
          else if (op_valid && op_kind == K_ALU)
            {flag_z, flag_c, flag_n, flag_v} <= {alu_z, alu_c, alu_n, alu_v};
          if (op_valid && op_kind == K_LOAD) begin
            lat_addr    <= op2;
            ld_dest     <= reg_addr_x;
            is_load     <= 1'b1;
            data_mem_rd <= 1'b1;
            busy        <= 1'b1;
            state       <= MEM_WAIT;
          end else if (op_valid && op_kind == K_STORE) begin
            lat_addr    <= op2;
            lat_data    <= rd_x;
            is_load     <= 1'b0;
            data_mem_wr <= 1'b1;
            busy        <= 1'b1;
            state       <= MEM_WAIT;
          end
        end
        MEM_WAIT: if (data_mem_ack) begin
          data_mem_rd <= 1'b0;
          data_mem_wr <= 1'b0;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_minirisc_datapath_p.sv
// Bench for minirisc_datapath_p: directed scenarios with literal expectations, then random
// traffic checked every cycle against a transaction-level model of the datapath.

module tb_minirisc_datapath_p;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       op_valid, op2_sel, flag_wr, dbg_is_brk, dbg_reg_wr, data_mem_ack;
  logic [1:0] op_kind;
  logic [2:0] alu_op;
  logic [7:0] const_data, data_mem_din, dbg_data_in;
  logic [3:0] reg_addr_x, reg_addr_y, dbg_addr_in, flag_din;
  logic       busy, data_mem_rd, data_mem_wr, flag_z, flag_c, flag_n, flag_v;
  logic [7:0] data_mem_addr, data_mem_dout, jump_address, dbg_reg_dout;

  logic        b_op_valid, b_flag_wr;
  logic [2:0]  b_alu_op, b_x;
  logic [15:0] b_const;
  logic [3:0]  b_flag_din;
  logic        b_busy, b_rd, b_wr, b_z, b_c, b_n, b_v;
  logic [15:0] b_addr, b_dout, b_jump, b_dbg_dout;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  minirisc_datapath_p #(.DATA_W(8), .REG_NUM(16)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_kind(op_kind), .alu_op(alu_op),
    .op2_sel(op2_sel), .const_data(const_data), .reg_addr_x(reg_addr_x),
    .reg_addr_y(reg_addr_y), .flag_din(flag_din), .flag_wr(flag_wr), .busy(busy),
    .data_mem_addr(data_mem_addr), .data_mem_dout(data_mem_dout),
    .data_mem_din(data_mem_din), .data_mem_rd(data_mem_rd), .data_mem_wr(data_mem_wr),
    .data_mem_ack(data_mem_ack), .flag_z(flag_z), .flag_c(flag_c), .flag_n(flag_n),
    .flag_v(flag_v), .jump_address(jump_address), .dbg_is_brk(dbg_is_brk),
    .dbg_addr_in(dbg_addr_in), .dbg_data_in(dbg_data_in), .dbg_reg_wr(dbg_reg_wr),
    .dbg_reg_dout(dbg_reg_dout)
  );

  minirisc_datapath_p #(.DATA_W(16), .REG_NUM(8)) dut16 (
    .clk(clk), .rst_n(rst_n), .op_valid(b_op_valid), .op_kind(2'd0), .alu_op(b_alu_op),
    .op2_sel(1'b0), .const_data(b_const), .reg_addr_x(b_x), .reg_addr_y(3'd0),
    .flag_din(b_flag_din), .flag_wr(b_flag_wr), .busy(b_busy), .data_mem_addr(b_addr),
    .data_mem_dout(b_dout), .data_mem_din(16'd0), .data_mem_rd(b_rd), .data_mem_wr(b_wr),
    .data_mem_ack(1'b0), .flag_z(b_z), .flag_c(b_c), .flag_n(b_n), .flag_v(b_v),
    .jump_address(b_jump), .dbg_is_brk(1'b0), .dbg_addr_in(3'd0), .dbg_data_in(16'd0),
    .dbg_reg_wr(1'b0), .dbg_reg_dout(b_dbg_dout)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model (8-bit instance) ----------------
  logic [7:0] m_rf [16];
  logic       m_z, m_c, m_n, m_v, m_busy, m_load;
  logic [7:0] m_addr, m_data, m_o2, m_r;
  logic [3:0] m_dest;

  task automatic alu_ref(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y,
                         inout logic c, inout logic v, output logic [7:0] r);
    int ux, uy, sx, sy, t;
    ux = int'(x); uy = int'(y);
    sx = (ux >= 128) ? ux - 256 : ux;
    sy = (uy >= 128) ? uy - 256 : uy;
    r = 8'h00;
    case (op)
      3'd0: begin t = ux + uy; r = 8'(t & 255); c = t > 255; v = (sx + sy > 127) || (sx + sy < -128); end
      3'd1: begin t = ux - uy; r = 8'(t & 255); c = ux < uy; v = (sx - sy > 127) || (sx - sy < -128); end
      3'd2: r = x & y;
      3'd3: r = x | y;
      3'd4: r = x ^ y;
      3'd5: r = y;
      3'd6: begin r = 8'((ux * 2) & 255); c = ux >= 128; end
      default: begin r = 8'(ux / 2); c = (ux % 2) == 1; end
    endcase
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) m_rf[i] = 8'h00;
      {m_z, m_c, m_n, m_v} = 4'b0000;
      m_busy = 1'b0; m_load = 1'b0; m_addr = 8'h00; m_data = 8'h00; m_dest = 4'h0;
    end else if (!m_busy) begin
      if (dbg_is_brk) begin
        if (dbg_reg_wr) m_rf[dbg_addr_in] = dbg_data_in;
      end else begin
        m_o2 = op2_sel ? m_rf[reg_addr_y] : const_data;
        if (op_valid) begin
          if (op_kind == 2'd0) begin
            logic c, v;
            c = m_c; v = m_v;
            alu_ref(alu_op, m_rf[reg_addr_x], m_o2, c, v, m_r);
            m_rf[reg_addr_x] = m_r;
            if (!flag_wr) {m_z, m_c, m_n, m_v} = {m_r == 8'h00, c, m_r >= 8'h80, v};
          end else if (op_kind == 2'd1) begin
            m_busy = 1'b1; m_load = 1'b1; m_addr = m_o2; m_dest = reg_addr_x;
          end else if (op_kind == 2'd2) begin
            m_busy = 1'b1; m_load = 1'b0; m_addr = m_o2; m_data = m_rf[reg_addr_x];
          end
        end
        if (flag_wr) {m_z, m_c, m_n, m_v} = flag_din;
      end
    end else if (data_mem_ack) begin
      if (m_load) m_rf[m_dest] = data_mem_din;
      m_busy = 1'b0;
    end
  end

  // Per-cycle comparison of every observable output against the model
  logic [3:0] e_xa;
  logic [7:0] e_o2;
  always @(negedge clk) begin
    e_xa = (dbg_is_brk && !m_busy) ? dbg_addr_in : reg_addr_x;
    e_o2 = op2_sel ? m_rf[reg_addr_y] : const_data;
    chk("busy", busy, m_busy);
    chk("mem_rd", data_mem_rd, m_busy && m_load);
    chk("mem_wr", data_mem_wr, m_busy && !m_load);
    chk("mem_addr", data_mem_addr, m_busy ? m_addr : e_o2);
    chk("mem_dout", data_mem_dout, m_busy ? m_data : m_rf[e_xa]);
    chk("jump", jump_address, e_o2);
    chk("dbg_dout", dbg_reg_dout, m_rf[e_xa]);
    chk("flags", {flag_z, flag_c, flag_n, flag_v}, {m_z, m_c, m_n, m_v});
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic op(input logic [1:0] k, input logic [2:0] a, input logic [7:0] c, input logic [3:0] x);
    op_valid = 1'b1; op_kind = k; alu_op = a; op2_sel = 1'b0; const_data = c; reg_addr_x = x;
    tick();
    op_valid = 1'b0;
  endtask

  task automatic chk_reg(input string nm, input logic [3:0] a, input logic [7:0] exp);
    reg_addr_x = a; #1;
    chk(nm, dbg_reg_dout, exp);
  endtask

  task automatic bop(input logic [2:0] a, input logic [15:0] c, input logic fw, input logic [3:0] fd);
    b_op_valid = 1'b1; b_alu_op = a; b_const = c; b_x = 3'd1; b_flag_wr = fw; b_flag_din = fd;
    tick();
    b_op_valid = 1'b0; b_flag_wr = 1'b0;
  endtask

  initial begin
    op_valid = 0; op_kind = 0; alu_op = 0; op2_sel = 0; const_data = 0; reg_addr_x = 0;
    reg_addr_y = 0; flag_din = 0; flag_wr = 0; dbg_is_brk = 0; dbg_reg_wr = 0;
    dbg_addr_in = 0; dbg_data_in = 0; data_mem_ack = 0; data_mem_din = 0;
    b_op_valid = 0; b_flag_wr = 0; b_alu_op = 0; b_x = 0; b_const = 0; b_flag_din = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_flags", {flag_z, flag_c, flag_n, flag_v}, 4'b0000);

    // ADD overflow, then SUB to zero
    op(2'd0, 3'd5, 8'h7F, 4'd1);
    op(2'd0, 3'd0, 8'h01, 4'd1);
    chk_reg("add_r", 4'd1, 8'h80);
    chk("add_flags", {flag_z, flag_c, flag_n, flag_v}, 4'b0011);
    op(2'd0, 3'd1, 8'h80, 4'd1);
    chk_reg("sub_r", 4'd1, 8'h00);
    chk("sub_flags", {flag_z, flag_c, flag_n, flag_v}, 4'b1000);

    // Shifts: carry out, V held
    op(2'd0, 3'd5, 8'h01, 4'd2);
    op(2'd0, 3'd7, 8'h00, 4'd2);
    chk_reg("shr_r", 4'd2, 8'h00);
    chk("shr_flags", {flag_z, flag_c, flag_n, flag_v}, 4'b1100);
    op(2'd0, 3'd5, 8'h81, 4'd2);
    flag_wr = 1'b1; flag_din = 4'b0001;
    tick();
    flag_wr = 1'b0;
    op(2'd0, 3'd6, 8'h00, 4'd2);
    chk_reg("shl_r", 4'd2, 8'h02);
    chk("shl_flags", {flag_z, flag_c, flag_n, flag_v}, 4'b0101);

    // LOAD with three wait states and an ignored op while busy
    op(2'd1, 3'd0, 8'h20, 4'd4);
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin op_valid = 1'b1; op_kind = 2'd0; alu_op = 3'd5; const_data = 8'hFF; reg_addr_x = 4'd5; end
      if (i == 3) begin data_mem_ack = 1'b1; data_mem_din = 8'hA5; end
      #1;
      chk("ld_rd", data_mem_rd, 1'b1);
      chk("ld_busy", busy, 1'b1);
      chk("ld_addr", data_mem_addr, 8'h20);
      tick();
      op_valid = 1'b0; data_mem_ack = 1'b0;
    end
    chk("ld_done_busy", busy, 1'b0);
    chk("ld_done_rd", data_mem_rd, 1'b0);
    chk_reg("ld_r", 4'd4, 8'hA5);
    chk_reg("ld_ignored", 4'd5, 8'h00);

    // Breakpoint raised during a STORE: the store still completes
    op(2'd2, 3'd0, 8'h30, 4'd4);
    dbg_is_brk = 1'b1; #1;
    chk("st_wr", data_mem_wr, 1'b1);
    chk("st_dout", data_mem_dout, 8'hA5);
    chk("st_addr", data_mem_addr, 8'h30);
    tick();
    data_mem_ack = 1'b1; #1;
    chk("st_wr_hold", data_mem_wr, 1'b1);
    tick();
    data_mem_ack = 1'b0; #1;
    chk("st_done_wr", data_mem_wr, 1'b0);
    chk("st_done_busy", busy, 1'b0);
    dbg_addr_in = 4'd3; dbg_data_in = 8'h5C; dbg_reg_wr = 1'b1;
    op_valid = 1'b1; op_kind = 2'd0; alu_op = 3'd5; const_data = 8'h11; reg_addr_x = 4'd6;
    flag_wr = 1'b1; flag_din = 4'b1111;
    tick();
    op_valid = 1'b0; flag_wr = 1'b0; dbg_reg_wr = 1'b0; #1;
    chk("dbg_rd", dbg_reg_dout, 8'h5C);
    chk("dbg_flags", {flag_z, flag_c, flag_n, flag_v}, 4'b0101);
    dbg_is_brk = 1'b0;
    chk_reg("dbg_op_ignored", 4'd6, 8'h00);
    tick();
    chk_reg("dbg_reg3", 4'd3, 8'h5C);

    // Asynchronous reset in the middle of a LOAD
    op(2'd1, 3'd0, 8'h40, 4'd7);
    tick();
    #1 rst_n = 1'b0;
    #1;
    chk("arst_rd", data_mem_rd, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_flags", {flag_z, flag_c, flag_n, flag_v}, 4'b0000);
    rst_n = 1'b1;
    for (int a = 0; a < 16; a++) begin
      chk_reg("arst_reg", 4'(a), 8'h00);
      tick();
    end

    // Randomized traffic, checked by the per-cycle compare process
    repeat (3000) begin
      op_valid     = ($urandom_range(0, 1) == 1);
      op_kind      = 2'($urandom_range(0, 3));
      alu_op       = 3'($urandom_range(0, 7));
      op2_sel      = ($urandom_range(0, 1) == 1);
      const_data   = 8'($urandom_range(0, 255));
      reg_addr_x   = 4'($urandom_range(0, 15));
      reg_addr_y   = 4'($urandom_range(0, 15));
      flag_wr      = ($urandom_range(0, 7) == 0);
      flag_din     = 4'($urandom_range(0, 15));
      data_mem_ack = ($urandom_range(0, 2) == 0);
      data_mem_din = 8'($urandom_range(0, 255));
      dbg_is_brk   = ($urandom_range(0, 15) == 0);
      dbg_reg_wr   = ($urandom_range(0, 1) == 1);
      dbg_addr_in  = 4'($urandom_range(0, 15));
      dbg_data_in  = 8'($urandom_range(0, 255));
      tick();
    end
    op_valid = 0; flag_wr = 0; dbg_is_brk = 0; dbg_reg_wr = 0; data_mem_ack = 0;

    // 16-bit / 8-register instance
    bop(3'd5, 16'hFFFF, 1'b0, 4'b0000);
    bop(3'd0, 16'h0001, 1'b0, 4'b0000);
    chk("w16_add_r", b_dbg_dout, 16'h0000);
    chk("w16_add_flags", {b_z, b_c, b_n, b_v}, 4'b1100);
    bop(3'd5, 16'hFFFF, 1'b0, 4'b0000);
    bop(3'd0, 16'h0001, 1'b1, 4'b0101);
    chk("w16_fwr_r", b_dbg_dout, 16'h0000);
    chk("w16_fwr_flags", {b_z, b_c, b_n, b_v}, 4'b0101);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
